// File: rtl/frame_uart_sender_pkg.sv
// Shared image-path constants (80x80 frame geometry, UART timing) for the frame
// sender and receiver, plus the sender FSM state encoding.
package frame_uart_sender_pkg;

  localparam int IMG_W          = 80;
  localparam int IMG_H          = 80;
  localparam int IMG_FRAME_SIZE = IMG_W * IMG_H;
  localparam int IMG_ADDR_W     = 13;

  // 115200 baud from a 25 MHz clock
  localparam int UART_CLKS_PER_BIT = 217;

  // Receiver side: samples each bit at its midpoint
  localparam int RX_CLKS_PER_BIT = UART_CLKS_PER_BIT;
  localparam int RX_HALF_BIT     = RX_CLKS_PER_BIT / 2;
  localparam int RX_DATA_BITS    = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_SEND,
    S_DONE
  } sender_state_t;

endpackage

// File: rtl/frame_uart_sender_serializer.sv
// 8N1 UART bit serializer: loads {stop, data, start} into a shift frame and
// shifts it out LSB first, one bit every CLKS_PER_BIT clocks.
module uart_tx_serializer #(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] data,
  output logic       ready,
  output logic       last_tick,
  output logic       txd
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

  logic [9:0]    shift;
  logic [CW-1:0] baud_cnt;
  logic [3:0]    bit_cnt;
  logic          active;
  logic          bit_end;

  assign bit_end   = active && (baud_cnt == BAUD_LAST);
  // Fires on the final clock of the stop bit so the caller can turn around
  // on the same edge the serializer goes idle.
  assign last_tick = bit_end && (bit_cnt == 4'd9);
  assign ready     = !active;
  // Gating by active lets an async reset raise the line without a clock edge.
  assign txd       = active ? shift[0] : 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift    <= 10'h3FF;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      active   <= 1'b0;
    end else if (load && !active) begin
      shift    <= {1'b1, data, 1'b0};
      baud_cnt <= '0;
      bit_cnt  <= '0;
      active   <= 1'b1;
    end else if (active) begin
      if (bit_end) begin
        baud_cnt <= '0;
        if (last_tick) begin
          active <= 1'b0;
        end else begin
          shift   <= {1'b1, shift[9:1]};
          bit_cnt <= bit_cnt + 4'd1;
        end
      end else begin
        baud_cnt <= baud_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/frame_uart_sender.sv
// Streams one full frame from the processed-image RAM over UART: fetches each
// byte (one-cycle RAM latency), hands it to the serializer, pulses done at end.
module frame_uart_sender
  import frame_uart_sender_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int FRAME_SIZE   = IMG_FRAME_SIZE,
  parameter int ADDR_W       = IMG_ADDR_W
) (
  input  logic              clk,
  input  logic              RESET,
  input  logic              start,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [7:0]        ram_data,
  output logic              txd,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_SIZE - 1);

  sender_state_t     state, state_next;
  logic [ADDR_W-1:0] index, index_next;
  logic              load;
  logic              ready;
  logic              last_tick;

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state <= S_IDLE;
      index <= '0;
    end else begin
      state <= state_next;
      index <= index_next;
    end
  end

  always_comb begin
    state_next = state;
    index_next = index;
    load       = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_next = S_FETCH;
          index_next = '0;
        end
      end
      S_FETCH: state_next = S_LOAD;
      S_LOAD: begin
        if (ready) begin
          load       = 1'b1;
          state_next = S_SEND;
        end
      end
      S_SEND: begin
        if (last_tick) begin
          if (index < LAST_IDX) begin
            index_next = index + 1'b1;
            state_next = S_FETCH;
          end else begin
            state_next = S_DONE;
          end
        end
      end
      S_DONE: begin
        index_next = '0;
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
        index_next = '0;
      end
    endcase
  end

  assign ram_addr = (state == S_IDLE) ? '0 : index;
  assign busy     = (state != S_IDLE);
  assign done     = (state == S_DONE);

  uart_tx_serializer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_serializer (
    .clk      (clk),
    .rst      (RESET),
    .load     (load),
    .data     (ram_data),
    .ready    (ready),
    .last_tick(last_tick),
    .txd      (txd)
  );

endmodule

// File: tb/tb_frame_uart_sender.sv
// Scoreboard bench for frame_uart_sender: stimulus pushes expected bytes, start
// bit times and done times; a txd decoder and done monitor pop and compare.
module tb_frame_uart_sender;

  localparam int CPB    = 4;
  localparam int FSIZE  = 4;
  localparam int AW     = 13;
  localparam int BYTE_T = 10 * CPB + 2;        // 42 clk per byte
  localparam int FRAME_T = FSIZE * BYTE_T;     // done edge offset from start edge
  localparam int REPEAT_T = FRAME_T + 2;       // DONE + IDLE before a held start restarts

  typedef struct {
    logic [7:0] data;
    int         fall;
  } exp_byte_t;

  logic          clk = 1'b0;
  logic          RESET = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_data = 8'h00;
  logic          txd;
  logic          busy;
  logic          done;

  logic [7:0] mem [FSIZE] = '{8'h55, 8'hA3, 8'h00, 8'hFF};

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int max_addr = 0;

  exp_byte_t exp_q[$];
  int        done_q[$];

  frame_uart_sender #(
    .CLKS_PER_BIT(CPB),
    .FRAME_SIZE  (FSIZE),
    .ADDR_W      (AW)
  ) dut (
    .clk     (clk),
    .RESET   (RESET),
    .start   (start),
    .ram_addr(ram_addr),
    .ram_data(ram_data),
    .txd     (txd),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // One-cycle-latency RAM model
  always @(posedge clk) ram_data <= mem[ram_addr[1:0]];

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, got, got, exp, exp, cyc);
    end
  endtask

  task automatic push_frame(input int n);
    for (int k = 0; k < FSIZE; k++) begin
      exp_q.push_back('{data: mem[k], fall: n + 2 + BYTE_T * k});
    end
    done_q.push_back(n + FRAME_T);
  endtask

  // ---------------- monitor: UART decoder + done checker ----------------
  bit          rx_active = 0;
  int          rx_cnt = 0;
  int          rx_fall = 0;
  logic [39:0] rx_bits;
  bit          busy_chk = 0;

  task automatic finish_byte();
    logic [7:0] d;
    bit         held;
    exp_byte_t  e;
    held = 1;
    for (int b = 0; b < 10; b++)
      for (int s = 1; s < CPB; s++)
        if (rx_bits[b*CPB+s] !== rx_bits[b*CPB]) held = 0;
    for (int b = 0; b < 8; b++) d[b] = rx_bits[(b+1)*CPB + 1];
    check("bit_hold", int'(held), 1);
    check("stop_bit", int'(rx_bits[9*CPB+1]), 1);
    if (exp_q.size() == 0) begin
      check("unexpected_byte", int'(d), -1);
    end else begin
      e = exp_q.pop_front();
      check("byte_data", int'(d), int'(e.data));
      check("start_bit_time", rx_fall, e.fall);
      $display("byte 0x%02h start bit at cycle %0d", d, rx_fall);
    end
  endtask

  always @(negedge clk) begin
    if (int'(ram_addr) > max_addr) max_addr = int'(ram_addr);
    if (RESET) begin
      rx_active = 0;
      busy_chk  = 0;
    end else begin
      if (!rx_active) begin
        if (txd == 1'b0) begin
          rx_active  = 1;
          rx_fall    = cyc;
          rx_bits[0] = txd;
          rx_cnt     = 1;
        end
      end else begin
        rx_bits[rx_cnt] = txd;
        rx_cnt++;
        if (rx_cnt == 10 * CPB) begin
          rx_active = 0;
          finish_byte();
        end
      end
      if (busy_chk) begin
        check("busy_after_done", int'(busy), 0);
        busy_chk = 0;
      end
      if (done) begin
        check("busy_in_done", int'(busy), 1);
        check("txd_in_done", int'(txd), 1);
        if (done_q.size() == 0) check("unexpected_done", cyc, -1);
        else check("done_time", cyc, done_q.pop_front());
        $display("done pulse at cycle %0d", cyc);
        busy_chk = 1;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic pulse_start(output int n);
    @(negedge clk);
    start = 1'b1;
    n = cyc + 1;
    push_frame(n);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic drain(input int budget, input string name);
    int i;
    i = 0;
    while ((exp_q.size() != 0 || done_q.size() != 0 || rx_active || busy) && i < budget) begin
      @(negedge clk);
      i++;
    end
    check({name, "_drain_timeout"}, int'(i >= budget), 0);
    repeat (20) @(negedge clk);
    check({name, "_idle_busy"}, int'(busy), 0);
    check({name, "_idle_txd"}, int'(txd), 1);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check("reset_txd", int'(txd), 1);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_addr", int'(ram_addr), 0);
    RESET = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_busy", int'(busy), 0);

    // Plain frame
    pulse_start(n);
    $display("frame A start accepted at edge %0d", n);
    check("busy_after_start", int'(busy), 1);
    drain(400, "frameA");

    // Extra starts during byte 1 and in the DONE cycle must be ignored
    pulse_start(n);
    $display("frame B start accepted at edge %0d", n);
    wait_cyc(n + 49);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_cyc(n + FRAME_T);
    check("done_at_ignored_start", int'(done), 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain(400, "frameB");

    // Reset during d3 of byte 2 (0x00 -> line low there)
    @(negedge clk);
    start = 1'b1;
    n = cyc + 1;
    for (int k = 0; k < 2; k++) exp_q.push_back('{data: mem[k], fall: n + 2 + BYTE_T * k});
    @(negedge clk);
    start = 1'b0;
    wait_cyc(n + 2 + 2 * BYTE_T + 4 * CPB + 1);
    check("txd_before_reset", int'(txd), 0);
    #2 RESET = 1'b1;
    #1;
    check("txd_on_reset", int'(txd), 1);
    check("busy_on_reset", int'(busy), 0);
    check("done_on_reset", int'(done), 0);
    check("addr_on_reset", int'(ram_addr), 0);
    check("bytes_before_reset", exp_q.size(), 0);
    repeat (2) @(negedge clk);
    RESET = 1'b0;
    repeat (30) @(negedge clk);
    check("idle_after_reset_busy", int'(busy), 0);
    check("idle_after_reset_txd", int'(txd), 1);
    pulse_start(n);
    $display("frame C start accepted at edge %0d", n);
    drain(400, "frameC");

    // start held for 400 clk: a new frame begins on each IDLE cycle it sees
    @(negedge clk);
    start = 1'b1;
    n = cyc + 1;
    for (int t = n; t <= n + 399; t += REPEAT_T) begin
      push_frame(t);
      $display("held start expects frame at edge %0d", t);
    end
    repeat (400) @(negedge clk);
    start = 1'b0;
    drain(800, "held");

    check("max_ram_addr", max_addr, FSIZE - 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
